dmem_responder: RTL and testbench

- Data-memory responder that services the pipeline's load/store requests over a valid/ready request channel and a valid/ready response channel.
- Sits between the CPU MEM stage (initiator) and a byte-organised 512-byte store, little-endian, with configurable access latency.
- Lets the pipeline stall on memory instead of assuming single-cycle data RAM.

---
 rtl/cpu_mem_pkg.sv | 24 ++
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_byte_array.sv | 33 +++
 rtl/dmem_responder.sv | 110 +++++++++++
 tb/tb_dmem_responder.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU data-memory path: FSM encoding, byte-lane
// layout of a 32-bit word and the load/store opcodes seen by the CPU adapter.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;

  // Little-endian: the byte at word address + k travels in bits [8k+7:8k].
  localparam bit LITTLE_ENDIAN = 1'b1;

  localparam logic [5:0] OP_LOAD  = 6'd35;
  localparam logic [5:0] OP_STORE = 6'd43;

  function automatic logic [1:0] lane_sel(input logic [1:0] k);
    return LITTLE_ENDIAN ? k : 2'(LANES - 1) - k;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channels between the MEM stage (master) and the
// data-memory responder (slave).
interface dmem_responder_if #(
  parameter int AW = 9
);
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_byte_array.sv
// Word-organised byte RAM: four byte lanes with per-lane write enables and a
// combinational word read port. Contents are never cleared.
module dmem_byte_array
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 512,
  parameter int AW          = 9
) (
  input  logic                     clka,
  input  logic [LANES-1:0]         we,
  input  logic [AW-1:2]            word_addr,
  input  logic [LANES*LANE_W-1:0]  wdata,
  output logic [LANES*LANE_W-1:0]  rdata
);

  localparam int WORDS = DEPTH_BYTES / LANES;

  logic [LANES-1:0][LANE_W-1:0] mem [WORDS];

  always_ff @(posedge clka) begin
    for (int k = 0; k < LANES; k++) begin
      if (we[k]) mem[word_addr][lane_sel(2'(k))] <= wdata[k*LANE_W +: LANE_W];
    end
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < LANES; k++) begin
      rdata[k*LANE_W +: LANE_W] = mem[word_addr][lane_sel(2'(k))];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding word load/store at a time, with a
// programmable number of wait cycles before the access and a held response.
module dmem_responder
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 512,
  parameter int AW          = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clka,
  input  logic              rst_n,
  dmem_responder_if.slave   bus,
  output logic              busy
);

  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            accept, do_access, misaligned;
  logic            write_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic            acc_write;
  logic [AW-1:0]   acc_addr;
  logic [31:0]     acc_wdata, rd_word, rdata_q;
  logic            err_q;
  logic [LANES-1:0] we;

  assign bus.req_ready = (state == IDLE) && rst_n;
  assign accept        = bus.req_ready && bus.req_valid;

  // With no wait cycles the access happens on the accept edge, straight from the request.
  assign acc_write  = (state == IDLE) ? bus.req_write : write_q;
  assign acc_addr   = (state == IDLE) ? bus.req_addr  : addr_q;
  assign acc_wdata  = (state == IDLE) ? bus.req_wdata : wdata_q;
  assign misaligned = |acc_addr[1:0];
  assign we         = {LANES{do_access && acc_write && !misaligned}};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    do_access = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_nxt = CW'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            do_access = 1'b1;
            state_nxt = RESP;
          end else begin
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          do_access = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (do_access) begin
        err_q   <= misaligned;
        rdata_q <= (!acc_write && !misaligned) ? rd_word : '0;
      end
    end
  end

  always_ff @(posedge clka) begin
    if (accept) begin
      write_q <= bus.req_write;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  dmem_byte_array #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .AW          (AW)
  ) u_array (
    .clka      (clka),
    .we        (we),
    .word_addr (acc_addr[AW-1:2]),
    .wdata     (acc_wdata),
    .rdata     (rd_word)
  );

  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait cycles) driven by
// directed transactions and checked every cycle against a transaction model.
module tb_dmem_responder;
  import cpu_mem_pkg::*;

  localparam int AW = 9;

  logic clka = 1'b0;
  logic rst_n;
  always #5 clka = ~clka;

  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  dmem_responder_if #(.AW(AW)) bus2 ();
  dmem_responder_if #(.AW(AW)) bus0 ();
  logic busy2, busy0;

  dmem_responder #(.DEPTH_BYTES(512), .AW(AW), .WAIT_CYCLES(2)) dut2 (
    .clka(clka), .rst_n(rst_n), .bus(bus2), .busy(busy2));
  dmem_responder #(.DEPTH_BYTES(512), .AW(AW), .WAIT_CYCLES(0)) dut0 (
    .clka(clka), .rst_n(rst_n), .bus(bus0), .busy(busy0));

  // index 0 -> dut2 (2 wait cycles), index 1 -> dut0 (no wait cycles)
  logic          rv [2];
  logic          rw [2];
  logic [AW-1:0] ra [2];
  logic [31:0]   rd [2];
  logic          rr [2];
  logic          s_rdy [2];
  logic          s_vld [2];
  logic [31:0]   s_rdata [2];
  logic          s_err [2];
  logic          s_busy [2];

  assign bus2.req_valid = rv[0];
  assign bus2.req_write = rw[0];
  assign bus2.req_addr  = ra[0];
  assign bus2.req_wdata = rd[0];
  assign bus2.rsp_ready = rr[0];
  assign bus0.req_valid = rv[1];
  assign bus0.req_write = rw[1];
  assign bus0.req_addr  = ra[1];
  assign bus0.req_wdata = rd[1];
  assign bus0.rsp_ready = rr[1];
  assign s_rdy[0]   = bus2.req_ready;
  assign s_vld[0]   = bus2.rsp_valid;
  assign s_rdata[0] = bus2.rsp_rdata;
  assign s_err[0]   = bus2.rsp_err;
  assign s_busy[0]  = busy2;
  assign s_rdy[1]   = bus0.req_ready;
  assign s_vld[1]   = bus0.rsp_valid;
  assign s_rdata[1] = bus0.rsp_rdata;
  assign s_err[1]   = bus0.rsp_err;
  assign s_busy[1]  = busy0;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Transaction model: a byte array plus one outstanding request and its age in clock edges.
  int          wait_of [2] = '{2, 0};
  logic [7:0]  mm [2][512];
  bit          out_m [2] = '{1'b0, 1'b0};
  bit          done_m [2] = '{1'b0, 1'b0};
  int          age [2] = '{0, 0};
  logic        pw [2];
  logic [AW-1:0] pa [2];
  logic [31:0] pd [2];
  logic [31:0] exp_rd [2];
  logic        exp_err [2];

  function automatic void model_access(input bit i);
    int a;
    a = int'(pa[i]);
    exp_rd[i] = 32'h0;
    exp_err[i] = 1'b0;
    if (a % 4 != 0) begin
      exp_err[i] = 1'b1;
    end else if (pw[i]) begin
      for (int k = 0; k < 4; k++) mm[i][9'((a + k) % 512)] = 8'(pd[i] >> (8 * k));
    end else begin
      for (int k = 0; k < 4; k++) exp_rd[i] = exp_rd[i] | (32'(mm[i][9'((a + k) % 512)]) << (8 * k));
    end
    done_m[i] = 1'b1;
  endfunction

  initial begin
    forever begin
      @(negedge clka);
      for (int k = 0; k < 2; k++) begin
        bit i;
        i = 1'(k);
        if (!rst_n) begin
          out_m[i] = 1'b0;
          done_m[i] = 1'b0;
        end
        chk($sformatf("req_ready_%0d", k), 32'(s_rdy[i]), 32'(rst_n && !out_m[i]));
        chk($sformatf("rsp_valid_%0d", k), 32'(s_vld[i]), 32'(out_m[i] && done_m[i]));
        chk($sformatf("busy_%0d", k), 32'(s_busy[i]), 32'(out_m[i]));
        if (out_m[i] && done_m[i]) begin
          chk($sformatf("rsp_rdata_%0d", k), s_rdata[i], exp_rd[i]);
          chk($sformatf("rsp_err_%0d", k), 32'(s_err[i]), 32'(exp_err[i]));
        end
        if (!rst_n) begin
          chk($sformatf("rst_rdata_%0d", k), s_rdata[i], 32'h0);
          chk($sformatf("rst_err_%0d", k), 32'(s_err[i]), 32'h0);
        end else if (out_m[i]) begin
          if (!done_m[i]) begin
            age[i]++;
            if (age[i] == wait_of[i] + 1) model_access(i);
          end else if (rr[i]) begin
            out_m[i] = 1'b0;
          end
        end else if (rv[i]) begin
          out_m[i] = 1'b1;
          done_m[i] = 1'b0;
          age[i] = 1;
          pw[i] = rw[i];
          pa[i] = ra[i];
          pd[i] = rd[i];
          if (wait_of[i] == 0) model_access(i);
        end
      end
    end
  end

  task automatic xfer(input bit i, input string tag, input logic [5:0] op, input logic [AW-1:0] addr,
                      input logic [31:0] wd, input int hold, input logic [31:0] xrd, input logic xerr,
                      output int lat, output int acc);
    bit ok;
    rv[i] = 1'b1; rw[i] = (op == OP_STORE); ra[i] = addr; rd[i] = wd; rr[i] = (hold == 0);
    ok = 1'b0;
    acc = 0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clka);
      if (s_rdy[i]) begin
        ok = 1'b1;
        acc = cyc;
      end
    end
    chk({tag, "_accept"}, 32'(ok), 32'd1);
    @(posedge clka); #1;
    // scramble the request lines: they must be ignored once accepted
    rv[i] = 1'b0; rw[i] = ~rw[i]; ra[i] = ~addr; rd[i] = ~wd;
    lat = 1;
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clka);
      if (s_vld[i]) ok = 1'b1;
      else lat++;
    end
    chk({tag, "_rsp"}, 32'(ok), 32'd1);
    chk({tag, "_rdata"}, s_rdata[i], xrd);
    chk({tag, "_err"}, 32'(s_err[i]), 32'(xerr));
    for (int n = 0; n < hold; n++) begin
      if (n > 0) @(negedge clka);
      chk({tag, "_hold_vld"}, 32'(s_vld[i]), 32'd1);
      chk({tag, "_hold_rdy"}, 32'(s_rdy[i]), 32'd0);
      chk({tag, "_hold_rdata"}, s_rdata[i], xrd);
      chk({tag, "_hold_err"}, 32'(s_err[i]), 32'(xerr));
    end
    if (hold > 0) begin
      @(posedge clka); #1;
      rr[i] = 1'b1;
      @(negedge clka);
      chk({tag, "_vld_at_ready"}, 32'(s_vld[i]), 32'd1);
    end
    @(posedge clka); #1;
    if (hold > 0) begin
      chk({tag, "_idle_rdy"}, 32'(s_rdy[i]), 32'd1);
      chk({tag, "_idle_busy"}, 32'(s_busy[i]), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, c0, c1;
    bit ok;
    for (int k = 0; k < 2; k++) begin
      rv[k] = 1'b0; rw[k] = 1'b0; ra[k] = '0; rd[k] = '0; rr[k] = 1'b1;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("por_rdy", 32'(s_rdy[0]), 32'd0);
    chk("por_vld", 32'(s_vld[0]), 32'd0);
    chk("por_busy", 32'(s_busy[0]), 32'd0);
    chk("por_rdata", s_rdata[0], 32'h0);
    chk("por_err", 32'(s_err[0]), 32'd0);
    repeat (2) @(posedge clka);
    #1 rst_n = 1'b1;
    @(posedge clka); #1;

    // store then load, two wait cycles
    xfer(1'b0, "st10", OP_STORE, 9'h010, 32'hDEADBEEF, 0, 32'h0, 1'b0, lat, c0);
    chk("st10_latency", 32'(lat), 32'd3);
    xfer(1'b0, "ld10", OP_LOAD, 9'h010, 32'h0, 0, 32'hDEADBEEF, 1'b0, lat, c1);
    chk("ld10_latency", 32'(lat), 32'd3);
    chk("turnaround_w2", 32'(c1 - c0), 32'd4);
    chk("byte_010", 32'(dut2.u_array.mem[4][0]), 32'h000000EF);
    chk("byte_013", 32'(dut2.u_array.mem[4][3]), 32'h000000DE);

    // misaligned store must not touch memory
    xfer(1'b0, "st11", OP_STORE, 9'h011, 32'h55AA55AA, 0, 32'h0, 1'b1, lat, c0);
    xfer(1'b0, "ld10b", OP_LOAD, 9'h010, 32'h0, 0, 32'hDEADBEEF, 1'b0, lat, c0);

    // response backpressure for five cycles
    xfer(1'b0, "bp", OP_LOAD, 9'h010, 32'h0, 5, 32'hDEADBEEF, 1'b0, lat, c0);

    // reset in the middle of a store
    xfer(1'b0, "st20", OP_STORE, 9'h020, 32'h11223344, 0, 32'h0, 1'b0, lat, c0);
    xfer(1'b0, "ld20", OP_LOAD, 9'h020, 32'h0, 0, 32'h11223344, 1'b0, lat, c0);
    rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 9'h020; rd[0] = 32'hCAFEF00D;
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clka);
      if (s_rdy[0]) ok = 1'b1;
    end
    chk("rst_st_accept", 32'(ok), 32'd1);
    @(posedge clka); #1;
    rv[0] = 1'b0;
    @(posedge clka); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_rdy", 32'(s_rdy[0]), 32'd0);
    chk("midrst_vld", 32'(s_vld[0]), 32'd0);
    chk("midrst_busy", 32'(s_busy[0]), 32'd0);
    chk("midrst_rdata", s_rdata[0], 32'h0);
    chk("midrst_err", 32'(s_err[0]), 32'd0);
    @(posedge clka); #1;
    rst_n = 1'b1;
    @(posedge clka); #1;
    xfer(1'b0, "ld20_after_rst", OP_LOAD, 9'h020, 32'h0, 0, 32'h11223344, 1'b0, lat, c0);

    // no wait cycles: top-of-memory word, no wrap into address 0
    xfer(1'b1, "st000", OP_STORE, 9'h000, 32'hA5A5A5A5, 0, 32'h0, 1'b0, lat, c0);
    xfer(1'b1, "st1fc", OP_STORE, 9'h1FC, 32'h01234567, 0, 32'h0, 1'b0, lat, c0);
    chk("st1fc_latency", 32'(lat), 32'd1);
    xfer(1'b1, "ld1fc", OP_LOAD, 9'h1FC, 32'h0, 0, 32'h01234567, 1'b0, lat, c1);
    chk("ld1fc_latency", 32'(lat), 32'd1);
    chk("turnaround_w0", 32'(c1 - c0), 32'd2);
    chk("byte_1fc", 32'(dut0.u_array.mem[127][0]), 32'h00000067);
    chk("byte_1ff", 32'(dut0.u_array.mem[127][3]), 32'h00000001);
    xfer(1'b1, "ld000", OP_LOAD, 9'h000, 32'h0, 0, 32'hA5A5A5A5, 1'b0, lat, c0);
    xfer(1'b1, "ld1fe", OP_LOAD, 9'h1FE, 32'h0, 0, 32'h0, 1'b1, lat, c0);

    repeat (3) @(posedge clka);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
